arc4_encrypt: RTL
=================

// Module: arc4_encrypt
// PURPOSE
//  ARC4 encryptor that produces ciphertext for the crack/decrypt path. It reads a length-prefixed plaintext
//  from pt memory, runs ARC4 init/KSA/PRGA with a 24-bit key on an external 256x8 S memory, and writes a
//  length-prefixed ciphertext to ct memory. doublecrack consumes this ct image unchanged.
// PARAMETERS
//  KEY_BYTES  3  key length in bytes; key byte for step i = key[8*(KEY_BYTES-1-(i%KEY_BYTES)) +: 8], MSB first
// PORTS
//  clk        in   1   clock; all state on rising edge
//  rst_n      in   1   asynchronous, active-low reset
//  en         in   1   start request; sampled only while rdy=1
//  rdy        out  1   1 = idle and able to accept en
//  key        in   24  cipher key; captured on the accepted-en cycle
//  pt_addr    out  8   plaintext memory read address
//  pt_rddata  in   8   plaintext read data; valid 1 cycle after pt_addr (registered RAM)
//  ct_addr    out  8   ciphertext memory write address
//  ct_wrdata  out  8   ciphertext write data
//  ct_wren    out  1   ciphertext write enable; one byte per asserted cycle
//  s_addr     out  8   S memory address
//  s_rddata   in   8   S read data; valid 1 cycle after s_addr
//  s_wrdata   out  8   S write data
//  s_wren     out  1   S write enable
// BEHAVIOUR
//  - Reset (async): state IDLE. rdy=1. All addresses, all wrdata, ct_wren and s_wren = 0.
//  - Handshake: en=1 with rdy=1 latches key. rdy=0 starting the next cycle. rdy returns to 1 one cycle after
//    the last ct write. en and key changes while rdy=0 are ignored.
//  - States: IDLE -> INIT -> KSA -> LEN -> PRGA -> DONE -> IDLE.
//  - INIT: 256 cycles, writes S[i]=i for i=0..255 (s_wren=1 each cycle).
//  - KSA: j=0. For i=0..255:
//      j=(j+S[i]+keybyte(i)) mod 256, then swap S[i] and S[j].
//      Each step is read S[i], read S[j], write S[i], write S[j].
//      If i==j the step still completes and leaves S unchanged.
//  - LEN: read pt[0]=L. Write ct[0]=L.
//  - PRGA: i=j=0. For z=1..L-1:
//      i=(i+1) mod 256; j=(j+S[i]) mod 256; swap S[i] and S[j];
//      pad=S[(S[i]+S[j]) mod 256]; ct[z]=pad^pt[z].
//    Sums are 8-bit and wrap. A swap read-after-write on the same address must return the written value.
//  - Boundaries:
//      L=0 or L=1: PRGA is skipped; only ct[0] is written.
//      L=255: ct[1..254] are written; no address exceeds 254.
//  - Exactly L_eff = max(L,1) ct writes per run, at strictly increasing addresses. No ct write ever lands
//    outside 0..L_eff-1.
//  - Latency bound (accepted en to rdy=1): <= 256 + 256*6 + 4 + (L-1)*9 + 2 cycles.
//  - Reset mid-operation: abort immediately and return to IDLE with reset output values. No further writes.
//    S and ct contents are then undefined.
//  - Back-to-back runs: en on the cycle rdy rises starts a fresh run. INIT rebuilds S; no state carries over.
// TESTING
//  - Reset: hold rst_n=0 -> rdy=1, ct_wren=0, s_wren=0. Release, en=0 for 10 cycles -> no writes at all.
//  - Known answer: key=24'h1E4600, pt from test1 plaintext -> ct bytes equal the bench ARC4 model.
//    The same ct fed to doublecrack yields key 1E4600 and identical plaintext.
//  - Empty message: pt[0]=8'h00, key=24'h000000 -> exactly one write, ct[0]=00, then rdy=1 within the bound.
//  - Max length: pt[0]=8'hFF, printable bytes, key=24'hFFFFFF.
//    -> 255 writes at addresses 0..254, matching the model. No write at address 255.
//  - Ignore/restart:
//      pulse en mid-run with a different key -> output is unaffected.
//      assert rst_n=0 during KSA -> rdy=1 asynchronously, no further writes; a new run then matches the model.
//  - Round-trip: random key and random printable L=50 message -> decrypt with the model using the same key
//    -> original plaintext recovered.

Source files
------------

// File: rtl/arc4_encrypt.sv
// ARC4 encryptor: reads a length-prefixed plaintext and runs S-box init, KSA and PRGA on an
// external 256x8 S RAM. It then writes a length-prefixed ciphertext image.
//
// state | meaning
// IDLE  | rdy=1, waiting for en; key captured on accept
// INIT  | S[i]=i for i=0..255, one write per cycle
// KSA   | key schedule, 6-phase step: rd S[i], rd S[j], wr S[i], wr S[j]
// LEN   | read pt[0]=L, write ct[0]=L
// PRGA  | 9-phase step per byte: swap, read pad, write ct[z]
// DONE  | raise rdy one cycle after the last ct write
module arc4_encrypt #(
    parameter int KEY_BYTES = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    output logic                   rdy,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic [7:0]             pt_addr,
    input  logic [7:0]             pt_rddata,
    output logic [7:0]             ct_addr,
    output logic [7:0]             ct_wrdata,
    output logic                   ct_wren,
    output logic [7:0]             s_addr,
    input  logic [7:0]             s_rddata,
    output logic [7:0]             s_wrdata,
    output logic                   s_wren
);

    localparam int KW = 8 * KEY_BYTES;

    typedef enum logic [2:0] {IDLE, INIT, KSA, LEN, PRGA, DONE} state_t;

    state_t        state;
    logic [3:0]    phase;
    logic [7:0]    i;
    logic [7:0]    j;
    logic [7:0]    si;
    logic [7:0]    sj;
    logic [7:0]    z;
    logic [7:0]    remain;
    logic [7:0]    pt_byte;
    logic [KW-1:0] key_sh;

    logic [7:0]    key_byte;
    logic [7:0]    ksa_j;
    logic [7:0]    prga_j;
    logic [7:0]    pad_addr;

    // The key is rotated one byte per KSA step, so the MSB byte is always keybyte(i).
    assign key_byte = key_sh[KW-1 -: 8];
    assign ksa_j    = j + s_rddata + key_byte;
    assign prga_j   = j + s_rddata;
    assign pad_addr = si + sj;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            phase     <= 4'd0;
            rdy       <= 1'b1;
            i         <= 8'd0;
            j         <= 8'd0;
            si        <= 8'd0;
            sj        <= 8'd0;
            z         <= 8'd0;
            remain    <= 8'd0;
            pt_byte   <= 8'd0;
            key_sh    <= '0;
            pt_addr   <= 8'd0;
            ct_addr   <= 8'd0;
            ct_wrdata <= 8'd0;
            ct_wren   <= 1'b0;
            s_addr    <= 8'd0;
            s_wrdata  <= 8'd0;
            s_wren    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ct_wren <= 1'b0;
                    s_wren  <= 1'b0;
                    if (en) begin
                        key_sh <= key;
                        rdy    <= 1'b0;
                        i      <= 8'd0;
                        state  <= INIT;
                    end
                end

                INIT: begin
                    s_addr   <= i;
                    s_wrdata <= i;
                    s_wren   <= 1'b1;
                    i        <= i + 8'd1;
                    if (i == 8'hFF) begin
                        j     <= 8'd0;
                        phase <= 4'd0;
                        state <= KSA;
                    end
                end

                // RAM reads land two edges after the address is registered, hence the wait phases.
                KSA: begin
                    case (phase)
                        4'd0: begin
                            s_wren <= 1'b0;
                            s_addr <= i;
                            phase  <= 4'd1;
                        end
                        4'd2: begin
                            si     <= s_rddata;
                            j      <= ksa_j;
                            s_addr <= ksa_j;
                            phase  <= 4'd3;
                        end
                        4'd4: begin
                            sj       <= s_rddata;
                            s_addr   <= i;
                            s_wrdata <= s_rddata;
                            s_wren   <= 1'b1;
                            phase    <= 4'd5;
                        end
                        4'd5: begin
                            s_addr   <= j;
                            s_wrdata <= si;
                            s_wren   <= 1'b1;
                            key_sh   <= (key_sh << 8) | (key_sh >> (KW - 8));
                            i        <= i + 8'd1;
                            phase    <= 4'd0;
                            if (i == 8'hFF) state <= LEN;
                        end
                        default: phase <= phase + 4'd1;
                    endcase
                end

                LEN: begin
                    case (phase)
                        4'd0: begin
                            s_wren  <= 1'b0;
                            pt_addr <= 8'd0;
                            phase   <= 4'd1;
                        end
                        4'd2: begin
                            ct_addr   <= 8'd0;
                            ct_wrdata <= pt_rddata;
                            ct_wren   <= 1'b1;
                            remain    <= pt_rddata - 8'd1;
                            i         <= 8'd0;
                            j         <= 8'd0;
                            z         <= 8'd1;
                            phase     <= 4'd0;
                            state     <= (pt_rddata <= 8'd1) ? DONE : PRGA;
                        end
                        default: phase <= phase + 4'd1;
                    endcase
                end

                PRGA: begin
                    case (phase)
                        4'd0: begin
                            ct_wren <= 1'b0;
                            i       <= i + 8'd1;
                            s_addr  <= i + 8'd1;
                            pt_addr <= z;
                            phase   <= 4'd1;
                        end
                        4'd2: begin
                            si      <= s_rddata;
                            j       <= prga_j;
                            s_addr  <= prga_j;
                            pt_byte <= pt_rddata;
                            phase   <= 4'd3;
                        end
                        4'd4: begin
                            sj       <= s_rddata;
                            s_addr   <= i;
                            s_wrdata <= s_rddata;
                            s_wren   <= 1'b1;
                            phase    <= 4'd5;
                        end
                        4'd5: begin
                            s_addr   <= j;
                            s_wrdata <= si;
                            s_wren   <= 1'b1;
                            phase    <= 4'd6;
                        end
                        4'd6: begin
                            // Issued after both swap writes commit, so a same-address read sees new data.
                            s_wren <= 1'b0;
                            s_addr <= pad_addr;
                            phase  <= 4'd7;
                        end
                        4'd8: begin
                            ct_addr   <= z;
                            ct_wrdata <= s_rddata ^ pt_byte;
                            ct_wren   <= 1'b1;
                            z         <= z + 8'd1;
                            remain    <= remain - 8'd1;
                            phase     <= 4'd0;
                            if (remain == 8'd1) state <= DONE;
                        end
                        default: phase <= phase + 4'd1;
                    endcase
                end

                DONE: begin
                    ct_wren <= 1'b0;
                    s_wren  <= 1'b0;
                    rdy     <= 1'b1;
                    state   <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
